// File: rtl/rr_mux8_stream.sv
// rr_mux8_stream: N-to-1 round-robin merge of valid/ready streams.
// Each output beat is tagged with its source lane on out_sel so a downstream
// demux can route it back. One registered output slot; a beat can be drained
// and a new one loaded in the same cycle.
// Optional packet lock: define RR_MUX8_PKT_LOCK_EN to add in_last/out_last and
// keep the grant on one lane until that lane's last beat has been accepted.

// Per-lane slice: qualifies the lane request and gates the lane data onto the
// AND-OR output mux using the one-hot grant.
module rr_mux8_lane #(
    parameter int WIDTH = 8
) (
    input  logic             valid,
    input  logic             allowed,
    input  logic             grant,
    input  logic [WIDTH-1:0] data,
    output logic             req,
    output logic [WIDTH-1:0] data_gated
);

    // Request only when the arbitration mode lets this lane compete.
    always_comb begin
        req        = valid & allowed;
        data_gated = grant ? data : '0;
    end

endmodule

module rr_mux8_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int SELW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
`ifdef RR_MUX8_PKT_LOCK_EN
    input  logic [N-1:0]         in_last,
    output logic                 out_last,
`endif
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    // Output slot and arbitration pointer.
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    // Arbitration intermediates.
    logic             load_en;
    logic [N-1:0]     allowed;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt_onehot;
    logic             gnt_found;
    logic [SELW-1:0]  gnt_idx;
    logic [SELW-1:0]  scan_idx;
    logic             accept;
    logic [N-1:0][WIDTH-1:0] lane_data_gated;
    logic [WIDTH-1:0] gnt_data;

`ifdef RR_MUX8_PKT_LOCK_EN
    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [SELW-1:0]  lock_sel_q, lock_sel_d;
    logic             out_last_q, out_last_d;
`endif

    // The slot can take a new beat when empty or when it is draining now.
    always_comb begin
        load_en = !out_valid_q || out_ready;
    end

    // Lanes eligible to compete: all of them, or only the locked lane.
    always_comb begin
        allowed = '1;
`ifdef RR_MUX8_PKT_LOCK_EN
        if (state_q == ST_LOCKED) begin
            allowed = '0;
            allowed[lock_sel_q] = 1'b1;
        end
`endif
    end

    // One slice per lane: request qualification and gated data.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            rr_mux8_lane #(.WIDTH(WIDTH)) u_lane (
                .valid      (in_valid[gi]),
                .allowed    (allowed[gi]),
                .grant      (gnt_onehot[gi]),
                .data       (in_data[gi*WIDTH +: WIDTH]),
                .req        (req[gi]),
                .data_gated (lane_data_gated[gi])
            );
        end
    endgenerate

    // Round-robin search: first requester at or above rr_ptr, wrapping.
    // N == 2**SELW, so the SELW-bit add wraps N-1 -> 0 by itself.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = rr_ptr_q + SELW'(k);
            if (!gnt_found && req[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // One-hot grant feeds the data mux; it does not depend on load_en so the
    // mux path stays independent of downstream ready.
    always_comb begin
        gnt_onehot = '0;
        if (gnt_found) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

    // OR-reduce the gated lane data into the granted beat.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            gnt_data = gnt_data | lane_data_gated[i];
        end
    end

    // Handshake strobe back to the granted lane; held low during reset.
    always_comb begin
        accept   = load_en && gnt_found;
        in_ready = '0;
        if (accept && !rst) begin
            in_ready = gnt_onehot;
        end
    end

    // Next state of the output slot and pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            if (gnt_found) begin
                out_valid_d = 1'b1;
                out_data_d  = gnt_data;
                out_sel_d   = gnt_idx;
                rr_ptr_d    = gnt_idx + 1'b1;
            end else begin
                // Drained with nothing to replace it: data/sel keep last beat.
                out_valid_d = 1'b0;
            end
        end
    end

`ifdef RR_MUX8_PKT_LOCK_EN
    // Packet lock FSM: a non-last beat from a lane pins the grant to it until
    // that lane delivers its last beat. out_last rides with the data slot.
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        out_last_d = out_last_q;
        if (accept) begin
            out_last_d = in_last[gnt_idx];
            case (state_q)
                ST_ARB: begin
                    if (!in_last[gnt_idx]) begin
                        state_d    = ST_LOCKED;
                        lock_sel_d = gnt_idx;
                    end
                end
                ST_LOCKED: begin
                    if (in_last[gnt_idx]) begin
                        state_d = ST_ARB;
                    end
                end
                default: state_d = ST_ARB;
            endcase
        end
    end

    // Lock state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ARB;
            lock_sel_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`endif

    // Output slot and pointer registers; reset discards any pending beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux8_stream.sv
// Directed bench for rr_mux8_stream (default 8 lanes x 8 bits).
// Packet-lock scenario is compiled in when RR_MUX8_PKT_LOCK_EN is defined.
module tb_rr_mux8_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_ready;
`ifdef RR_MUX8_PKT_LOCK_EN
    logic [7:0]  in_last;
    logic        out_last;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    rr_mux8_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_MUX8_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    // Advance one clock; inputs driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef RR_MUX8_PKT_LOCK_EN
        in_last   = '1;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 8'hFF;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef RR_MUX8_PKT_LOCK_EN
        in_last   = '1;
`endif
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 8'h00) $display("FAIL reset_data got %h exp 00", out_data);
        else pass_cnt++;
        total_cnt++;
        if (out_sel !== 3'd0) $display("FAIL reset_sel got %0d exp 0", out_sel);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 8'h00) $display("FAIL reset_in_ready got %h exp 00", in_ready);
        else pass_cnt++;
        in_valid = '0;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_lane();
        apply_reset();
        in_valid = 8'h20;
        in_data[5*8 +: 8] = 8'hA5;
        #1;
        total_cnt++;
        if (in_ready !== 8'h20) $display("FAIL single_ready got %h exp 20", in_ready);
        else pass_cnt++;
        tick();
        in_valid = '0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 3'd5)
            $display("FAIL single_beat got v=%0b d=%h s=%0d exp v=1 d=a5 s=5", out_valid, out_data, out_sel);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL single_drain got %0b exp 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_all_lanes();
        apply_reset();
        in_valid = 8'hFF;
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(i);
        #1;
        total_cnt++;
        if (in_ready !== 8'h01) $display("FAIL all_first_ready got %h exp 01", in_ready);
        else pass_cnt++;
        for (int c = 0; c < 10; c++) begin
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_sel !== 3'(c % 8) || out_data !== 8'(c % 8))
                $display("FAIL all_rotate[%0d] got v=%0b s=%0d d=%h exp v=1 s=%0d d=%h",
                         c, out_valid, out_sel, out_data, c % 8, 8'(c % 8));
            else pass_cnt++;
            total_cnt++;
            if (in_ready !== 8'(1 << ((c + 1) % 8)))
                $display("FAIL all_ready[%0d] got %h exp %h", c, in_ready, 8'(1 << ((c + 1) % 8)));
            else pass_cnt++;
        end
        in_valid = '0;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL all_drain got %0b exp 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 8'h04;
        in_data[2*8 +: 8] = 8'h3C;
        #1;
        total_cnt++;
        if (in_ready !== 8'h04) $display("FAIL bp_load_ready got %h exp 04", in_ready);
        else pass_cnt++;
        tick();
        in_valid = 8'h08;
        in_data[2*8 +: 8] = 8'hFF;
        in_data[3*8 +: 8] = 8'h77;
        #1;
        for (int c = 0; c < 4; c++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 3'd2 || in_ready !== 8'h00)
                $display("FAIL bp_stall[%0d] got v=%0b d=%h s=%0d rdy=%h exp v=1 d=3c s=2 rdy=00",
                         c, out_valid, out_data, out_sel, in_ready);
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 8'h08) $display("FAIL bp_release_ready got %h exp 08", in_ready);
        else pass_cnt++;
        tick();
        in_valid = '0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h77 || out_sel !== 3'd3)
            $display("FAIL bp_next_beat got v=%0b d=%h s=%0d exp v=1 d=77 s=3", out_valid, out_data, out_sel);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain got %0b exp 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        apply_reset();
        in_valid = 8'h40;
        in_data[6*8 +: 8] = 8'h66;
        in_data[7*8 +: 8] = 8'h77;
        in_data[1*8 +: 8] = 8'h11;
        in_data[2*8 +: 8] = 8'h22;
        tick();
        // pointer now 7
        in_valid = 8'h82;
        #1;
        total_cnt++;
        if (in_ready !== 8'h80) $display("FAIL wrap_ready7 got %h exp 80", in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_sel !== 3'd7 || out_data !== 8'h77)
            $display("FAIL wrap_beat7 got s=%0d d=%h exp s=7 d=77", out_sel, out_data);
        else pass_cnt++;
        in_valid = 8'h02;
        #1;
        total_cnt++;
        if (in_ready !== 8'h02) $display("FAIL wrap_ready1 got %h exp 02", in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_sel !== 3'd1 || out_data !== 8'h11)
            $display("FAIL wrap_beat1 got s=%0d d=%h exp s=1 d=11", out_sel, out_data);
        else pass_cnt++;
        // pointer should be 2: lane 2 wins over lane 1
        in_valid = 8'h06;
        #1;
        total_cnt++;
        if (in_ready !== 8'h04) $display("FAIL wrap_ptr2 got %h exp 04", in_ready);
        else pass_cnt++;
        in_valid = '0;
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        in_valid = 8'h10;
        in_data[4*8 +: 8] = 8'h44;
        tick();
        in_valid = '0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_sel !== 3'd4)
            $display("FAIL arst_pre got v=%0b s=%0d exp v=1 s=4", out_valid, out_sel);
        else pass_cnt++;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        in_valid = 8'h09;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 8'h00)
            $display("FAIL arst_drop got v=%0b rdy=%h exp v=0 rdy=00", out_valid, in_ready);
        else pass_cnt++;
        in_valid = '0;
        out_ready = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL arst_no_beat got %0b exp 0", out_valid);
        else pass_cnt++;
        in_valid = 8'h09;
        in_data[0*8 +: 8] = 8'h0A;
        in_data[3*8 +: 8] = 8'h3A;
        #1;
        total_cnt++;
        if (in_ready !== 8'h01) $display("FAIL arst_ptr0 got %h exp 01", in_ready);
        else pass_cnt++;
        tick();
        in_valid = '0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 8'h0A)
            $display("FAIL arst_beat got v=%0b s=%0d d=%h exp v=1 s=0 d=0a", out_valid, out_sel, out_data);
        else pass_cnt++;
        tick();
    endtask

`ifdef RR_MUX8_PKT_LOCK_EN
    task automatic test_pkt_lock();
        apply_reset();
        // single-beat packet from lane 0 moves the pointer to 1
        in_valid = 8'h01;
        in_last  = 8'hFF;
        tick();
        in_valid = 8'h03;
        for (int b = 0; b < 3; b++) begin
            in_data[1*8 +: 8] = 8'(8'h10 + b);
            in_last = (b == 2) ? 8'hFF : 8'hFD;
            #1;
            total_cnt++;
            if (in_ready !== 8'h02) $display("FAIL lock_ready[%0d] got %h exp 02", b, in_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_sel !== 3'd1 || out_data !== 8'(8'h10 + b) ||
                out_last !== (b == 2))
                $display("FAIL lock_beat[%0d] got v=%0b s=%0d d=%h l=%0b exp v=1 s=1 d=%h l=%0b",
                         b, out_valid, out_sel, out_data, out_last, 8'(8'h10 + b), b == 2);
            else pass_cnt++;
        end
        in_valid = 8'h01;
        #1;
        total_cnt++;
        if (in_ready !== 8'h01) $display("FAIL lock_release got %h exp 01", in_ready);
        else pass_cnt++;
        in_valid = '0;
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_lane();
        test_all_lanes();
        test_backpressure();
        test_wrap();
        test_async_reset();
`ifdef RR_MUX8_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rr_mux8_stream.md
Name: rr_mux8_stream

Overview:
- N-to-1 round-robin multiplexer for valid/ready streams; counterpart of the 1-to-8 demux.
- Merges N input lanes into one output stream.
- Tags each beat with its source lane index on out_sel, so a downstream demux can route the beat back by select.
- One-entry registered output stage; sits between lane producers and a shared serial channel.

Parameters:
- WIDTH, 8, data bits per lane.
- N, 8, number of input lanes; must equal 2**SELW; supported 2..8.
- SELW, 3, width of the lane index / select.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  N  per-lane valid.
- in_data  in  N*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  per-lane ready; at most one bit high in any cycle.
- out_valid  out  1  output beat valid.
- out_data  out  WIDTH  output beat data.
- out_sel  out  SELW  source lane of the current output beat.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (async, while rst=1):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready=all zeros.
- load_en = !out_valid || out_ready (output register is empty or is being drained this cycle).
- Grant (combinational):
  - First lane with in_valid=1, searching from rr_ptr upward, wrapping N-1 -> 0.
  - in_ready[g] = load_en and lane g requesting; all other in_ready bits are 0.
  - in_ready never depends on in_valid of the same lane beyond grant selection; in_ready is 0 whenever load_en=0.
- On clock edge with load_en=1 and a grant g:
  - out_data <= lane g data; out_sel <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod N; wraps from N-1 to 0.
- On clock edge with load_en=1 and no requester: out_valid <= 0; out_data and out_sel hold; rr_ptr holds.
- On clock edge with load_en=0 (stalled): all output registers and rr_ptr hold, data stable. Output AXI-style rule: once out_valid=1, out_data and out_sel stay stable until out_ready.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat/cycle with out_ready held at 1.
- Fairness: with all lanes requesting continuously, grants rotate 0,1,...,N-1,0; no lane waits more than N-1 grants.
- Simultaneous drain and load in the same cycle is a back-to-back transfer with no bubble.
- Reset asserted mid-stream: the pending output beat is discarded and out_valid drops immediately (async); no beat is emitted after deassertion until a new input handshake.

Optional Feature:
- Macro RR_MUX8_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (in, N) and out_last (out, 1); out_last is registered alongside out_data and resets to 0.
  - A state machine with states ARB and LOCKED.
  - ARB -> LOCKED on accepting a beat with in_last[g]=0; the locked lane is held in lock_sel.
  - In LOCKED, only lock_sel may be granted, even if other lanes request.
  - LOCKED -> ARB on accepting a beat from lock_sel with in_last=1; rr_ptr <= lock_sel+1.
  - Reset returns the FSM to ARB.
- Undefined: no in_last/out_last ports; arbitration is per beat as described above.

Test Plan:
- Single lane: lane 5 valid with data 0xA5, out_ready=1 -> in_ready[5]=1 that cycle; next cycle out_valid=1, out_data=0xA5, out_sel=5; then out_valid=0.
- All 8 lanes valid continuously, data=lane index, out_ready=1 -> out_sel sequence 0,1,2,...,7,0,1, one beat per cycle, no gaps.
- Backpressure: lane 2 data 0x3C accepted, out_ready=0 for 4 cycles -> out_data=0x3C and out_sel=2 stable for all 4 cycles, in_ready=0; out_ready=1 -> beat drains, lane 3 (if valid) loads same cycle.
- Wrap: rr_ptr=7, lanes 1 and 7 valid -> lane 7 granted first, then lane 1; rr_ptr ends at 2.
- Async reset: rst pulsed mid-cycle while out_valid=1 -> out_valid=0 immediately with no clock edge; rr_ptr=0 after release; lanes 3 and 0 valid -> lane 0 granted first.
- With RR_MUX8_PKT_LOCK_EN defined: lane 1 sends a 3-beat packet (last on beat 3) while lane 0 is also valid -> three consecutive beats with out_sel=1, out_last=1 on the third beat, then lane 2 if valid, else the search wraps to lane 0.
